// File: rtl/keypad_scan_reader.sv
// 4x4 matrix keypad scanner: column drive, row sync, scan classification,
// debounce FSM and one-cycle key strobe.
module keypad_scan_reader #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    DB_RELEASE
  } state_t;

  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    col_idx;
  logic          slot_end;
  logic          scan_end;

  logic [3:0]    low;
  logic [2:0]    hits;
  logic [1:0]    row_idx;
  logic [2:0]    tot;
  logic [1:0]    tot_sat;
  logic [3:0]    new_code;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;

  logic          scan_done;
  logic [1:0]    scan_kind;
  logic [3:0]    scan_code;

  state_t        state;
  state_t        state_n;
  logic [3:0]    cand;
  logic [3:0]    cand_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          accept;
  logic          valid_q;
  logic          single;
  logic          none;
  logic          last_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
    end
  end

  assign slot_end = (slot_cnt == SW'(SCAN_DIV - 1));
  assign scan_end = slot_end && (col_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      col_idx  <= 2'd0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      col_idx  <= col_idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
    end
  end

  assign col_out = ~(4'b0001 << col_idx);

  // Low-point count saturates at 2: anything beyond one point is a chord.
  always_comb begin
    low  = ~row_s2;
    hits = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
    row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (low[i]) row_idx = 2'(i);
    end
    tot      = {1'b0, acc_cnt} + hits;
    tot_sat  = (tot >= 3'd2) ? 2'd2 : tot[1:0];
    new_code = acc_code;
    if (acc_cnt == 2'd0 && hits == 3'd1) new_code = {row_idx, col_idx};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (slot_end) begin
      if (col_idx == 2'd3) begin
        acc_cnt  <= 2'd0;
        acc_code <= 4'd0;
      end else begin
        acc_cnt  <= tot_sat;
        acc_code <= new_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_done <= 1'b0;
      scan_kind <= 2'd0;
      scan_code <= 4'd0;
    end else begin
      scan_done <= scan_end;
      if (scan_end) begin
        scan_kind <= tot_sat;
        scan_code <= new_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cand     <= 4'd0;
      cnt      <= '0;
      key_code <= 4'd0;
      valid_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cand    <= cand_n;
      cnt     <= cnt_n;
      valid_q <= accept;
      if (accept) key_code <= cand_n;
    end
  end

  assign single   = (scan_kind == 2'd1);
  assign none     = (scan_kind == 2'd0);
  assign last_cnt = ((cnt + CW'(1)) == CW'(DEBOUNCE_SCANS));

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    accept  = 1'b0;
    if (scan_done) begin
      unique case (state)
        IDLE: begin
          if (single) begin
            cand_n = scan_code;
            if (DEBOUNCE_SCANS == 1) begin
              state_n = PRESSED;
              cnt_n   = '0;
              accept  = 1'b1;
            end else begin
              state_n = DB_PRESS;
              cnt_n   = CW'(1);
            end
          end
        end
        DB_PRESS: begin
          if (single && scan_code == cand) begin
            if (last_cnt) begin
              state_n = PRESSED;
              cnt_n   = '0;
              accept  = 1'b1;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end else if (single) begin
            cand_n = scan_code;
            cnt_n  = CW'(1);
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        PRESSED: begin
          if (none) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              state_n = DB_RELEASE;
              cnt_n   = CW'(1);
            end
          end
        end
        DB_RELEASE: begin
          if (none) begin
            if (last_cnt) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end else begin
            state_n = PRESSED;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_valid = valid_q;
    key_held  = (state == PRESSED) || (state == DB_RELEASE);
  end

endmodule

// File: tb/tb_keypad_scan_reader.sv
// Randomized scoreboard bench for keypad_scan_reader with a
// run-length debounce reference model and a combinational keypad.
module tb_keypad_scan_reader;

  localparam int SD   = 4;
  localparam int DB   = 2;
  localparam int SCAN = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = 16'h0;
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int t;
    int v;
  } ev_t;

  ev_t strobe_q[$];
  ev_t held_q[$];
  int  held_exp = 0;

  int m_held = 0;
  int m_run  = 0;
  int m_code = 0;
  int m_none = 0;

  keypad_scan_reader #(
    .SCAN_DIV(SD),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row_in(row_in),
    .col_out(col_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      logic [3:0] exp_col;
      exp_col = ~(4'b0001 << ((cyc / SD) % 4));
      chk("col_out", int'(col_out), int'(exp_col));
      if (cyc == 0) begin
        chk("reset_code", int'(key_code), 0);
        chk("reset_valid", int'(key_valid), 0);
      end
      while (held_q.size() > 0 && held_q[0].t <= cyc)
        held_exp = held_q.pop_front().v;
      chk("key_held", int'(key_held), held_exp);
      while (strobe_q.size() > 0 && strobe_q[0].t < cyc) begin
        ev_t e;
        e = strobe_q.pop_front();
        chk("missed_strobe_cycle", cyc, e.t);
      end
      if (key_valid) begin
        if (strobe_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          ev_t e;
          e = strobe_q.pop_front();
          chk("strobe_cycle", cyc, e.t);
          chk("strobe_code", int'(key_code), e.v);
        end
      end
    end
  end

  // One update per completed scan, from the set of pressed points alone.
  task automatic model_scan(input logic [15:0] m, input int s);
    int n;
    int k;
    int t;
    n = $countones(m);
    k = 0;
    for (int i = 0; i < 16; i++) if (m[i]) k = i;
    t = s * SCAN + SCAN + 1;
    if (m_held == 0) begin
      if (n == 1) begin
        if (m_run > 0 && m_code == k) m_run++;
        else begin
          m_run  = 1;
          m_code = k;
        end
        if (m_run == DB) begin
          strobe_q.push_back('{t, k});
          held_q.push_back('{t, 1});
          m_held = 1;
          m_none = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (n == 0) begin
        m_none++;
        if (m_none == DB) begin
          m_held = 0;
          m_run  = 0;
          held_q.push_back('{t, 0});
        end
      end else begin
        m_none = 0;
      end
    end
  endtask

  task automatic scan(input logic [15:0] m, input int n);
    repeat (n) begin
      keys = m;
      model_scan(m, cyc / SCAN);
      repeat (SCAN) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    strobe_q.delete();
    held_q.delete();
    held_exp = 0;
    m_held = 0;
    m_run  = 0;
    m_none = 0;
    m_code = 0;
  endtask

  function automatic logic [15:0] bit_of(input int k);
    logic [15:0] one;
    one = 16'h1;
    return one << k;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    int a;
    int b;
    logic [15:0] m;
    do_reset();
    scan(16'h0, 2);
    scan(bit_of(9), 6);
    scan(16'h0, 1);
    scan(bit_of(9), 2);
    scan(16'h0, 3);
    scan(bit_of(9), 3);
    scan(16'h0, 3);
    scan(bit_of(0), 1);
    scan(16'h0, 3);
    scan(bit_of(5) | bit_of(14), 4);
    scan(16'h0, 2);
    scan(bit_of(15), 3);
    scan(16'h0, 3);
    keys = bit_of(4);
    model_scan(keys, cyc / SCAN);
    repeat (SCAN + 5) @(posedge clk);
    #1;
    do_reset();
    scan(bit_of(4), 3);
    scan(16'h0, 3);
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35) begin
        m = 16'h0;
      end else if (r < 80) begin
        a = int'($urandom_range(0, 2));
        m = bit_of(a == 0 ? 2 : (a == 1 ? 7 : 11));
      end else begin
        a = int'($urandom_range(0, 15));
        b = (a + int'($urandom_range(1, 15))) % 16;
        m = bit_of(a) | bit_of(b);
      end
      scan(m, int'($urandom_range(1, 3)));
    end
    scan(16'h0, 3);
    repeat (20) @(posedge clk);
    #1;
    chk("strobes_pending", strobe_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
